// File: rtl/dmem_responder.sv
// Single-port data-memory responder: posted byte-lane writes, fixed-latency reads,
// sticky misalign/protocol flags and accepted-request counters.
module dmem_responder #(
    parameter int SCALE  = 12,
    parameter int RD_LAT = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] mem_addr,
    input  logic [3:0]  mem_oe,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_we,
    output logic [31:0] mem_rdata,
    output logic        mem_valid,
    output logic        mem_ready,
    output logic        misalign,
    output logic        proto_err,
    output logic [31:0] rd_cnt,
    output logic [31:0] wr_cnt
);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t      r_state;
    logic [1:0]  r_cnt;
    logic        r_ready;
    logic [31:0] r_pend;
    logic [31:0] r_ram [0:(1 << SCALE) - 1];

    logic             w_is_wr;
    logic             w_is_rd;
    logic [3:0]       w_mask;
    logic [1:0]       w_off;
    logic [SCALE-1:0] w_idx;
    logic             w_mis;
    logic             w_acc_wr;
    logic             w_acc_rd;
    logic [3:0]       w_lanes;
    logic [31:0]      w_wdata_sh;
    logic [31:0]      w_rd_word;
    logic [31:0]      w_byte_mask;
    logic [31:0]      w_rd_data;
    logic             w_unused;

    assign w_is_wr     = |mem_we;
    assign w_is_rd     = (|mem_oe) & ~w_is_wr;
    assign w_mask      = w_is_wr ? mem_we : mem_oe;
    assign w_off       = mem_addr[1:0];
    assign w_idx       = mem_addr[2 +: SCALE];
    assign w_mis       = ((w_mask == 4'b0011) && w_off[0]) ||
                         ((w_mask == 4'b1111) && (w_off != 2'b00));

    // Ready is masked by reset so requests in a reset cycle are never accepted.
    assign mem_ready   = r_ready & ~rst;
    assign w_acc_wr    = w_is_wr & mem_ready;
    assign w_acc_rd    = w_is_rd & mem_ready;

    assign w_lanes     = mem_we << w_off;
    assign w_wdata_sh  = mem_wdata << {w_off, 3'b000};
    assign w_rd_word   = r_ram[w_idx];
    assign w_byte_mask = {{8{mem_oe[3]}}, {8{mem_oe[2]}}, {8{mem_oe[1]}}, {8{mem_oe[0]}}};
    assign w_rd_data   = w_mis ? 32'd0 : ((w_rd_word >> {w_off, 3'b000}) & w_byte_mask);

    // Address bits above the word index are ignored, so the memory aliases.
    assign w_unused    = ^mem_addr[31:SCALE+2];

    // RAM has no reset; misaligned writes never reach it.
    always_ff @(posedge clk) begin
        if (w_acc_wr && !w_mis) begin
            for (int b = 0; b < 4; b++) begin
                if (w_lanes[b]) begin
                    r_ram[w_idx][8*b +: 8] <= w_wdata_sh[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_cnt     <= 2'd0;
            r_ready   <= 1'b1;
            r_pend    <= 32'd0;
            mem_valid <= 1'b0;
            mem_rdata <= 32'd0;
            misalign  <= 1'b0;
            proto_err <= 1'b0;
            rd_cnt    <= 32'd0;
            wr_cnt    <= 32'd0;
        end else begin
            mem_valid <= 1'b0;
            if ((w_is_wr || w_is_rd) && !r_ready) begin
                proto_err <= 1'b1;
            end
            if ((w_acc_wr || w_acc_rd) && w_mis) begin
                misalign <= 1'b1;
            end
            if (w_acc_wr) begin
                wr_cnt <= wr_cnt + 32'd1;
            end
            if (w_acc_rd) begin
                rd_cnt <= rd_cnt + 32'd1;
            end
            // Read data is captured at acceptance; WAIT only delays its release.
            case (r_state)
                IDLE, RESP: begin
                    r_state <= IDLE;
                    r_ready <= 1'b1;
                    if (w_acc_rd) begin
                        if (RD_LAT == 1) begin
                            r_state   <= RESP;
                            mem_valid <= 1'b1;
                            mem_rdata <= w_rd_data;
                        end else begin
                            r_state <= WAIT;
                            r_ready <= 1'b0;
                            r_cnt   <= 2'(RD_LAT - 1);
                            r_pend  <= w_rd_data;
                        end
                    end
                end
                WAIT: begin
                    r_cnt <= r_cnt - 2'd1;
                    if (r_cnt == 2'd1) begin
                        r_state   <= RESP;
                        r_ready   <= 1'b1;
                        mem_valid <= 1'b1;
                        mem_rdata <= r_pend;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: two instances (read latency 1 and 3) share one stimulus
// stream and are checked against a byte-array reference model.
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] addr;
    logic [3:0]  oe;
    logic [31:0] wdata;
    logic [3:0]  we;

    wire  [31:0] obsRdata [2];
    wire         obsValid [2];
    wire         obsReady [2];
    wire         obsMis   [2];
    wire         obsProto [2];
    wire  [31:0] obsRd    [2];
    wire  [31:0] obsWr    [2];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    int          lat [2] = '{1, 3};
    logic [7:0]  mdl [2][16384];
    int          dueCyc [2];
    int          lastRdAcc [2];
    logic [31:0] dueData [2];
    logic [31:0] expRdata [2];
    logic        mMis [2];
    logic        mProto [2];
    logic [31:0] mRd [2];
    logic [31:0] mWr [2];

    always #5 clk = ~clk;

    dmem_responder #(.SCALE(12), .RD_LAT(1)) dutA (
        .clk(clk), .rst(rst), .mem_addr(addr), .mem_oe(oe), .mem_wdata(wdata), .mem_we(we),
        .mem_rdata(obsRdata[0]), .mem_valid(obsValid[0]), .mem_ready(obsReady[0]),
        .misalign(obsMis[0]), .proto_err(obsProto[0]), .rd_cnt(obsRd[0]), .wr_cnt(obsWr[0])
    );

    dmem_responder #(.SCALE(12), .RD_LAT(3)) dutB (
        .clk(clk), .rst(rst), .mem_addr(addr), .mem_oe(oe), .mem_wdata(wdata), .mem_we(we),
        .mem_rdata(obsRdata[1]), .mem_valid(obsValid[1]), .mem_ready(obsReady[1]),
        .misalign(obsMis[1]), .proto_err(obsProto[1]), .rd_cnt(obsRd[1]), .wr_cnt(obsWr[1])
    );

    // A read accepted in cycle T blocks new requests in T+1 .. T+lat-1.
    function automatic bit modelReady(input int k);
        return !((cyc > lastRdAcc[k]) && (cyc < lastRdAcc[k] + lat[k]));
    endfunction

    function automatic bit modelValid(input int k);
        return cyc == dueCyc[k];
    endfunction

    task automatic modelAccept(input int k);
        logic [3:0] m;
        int         off;
        int         base;
        bit         wr;
        bit         rd;
        bit         mis;
        if (rst) begin
            dueCyc[k]    = -1;
            lastRdAcc[k] = -100;
            expRdata[k]  = 32'd0;
            mMis[k]      = 1'b0;
            mProto[k]    = 1'b0;
            mRd[k]       = 32'd0;
            mWr[k]       = 32'd0;
            return;
        end
        wr = |we;
        rd = (|oe) && !wr;
        if (!wr && !rd) return;
        if (!modelReady(k)) begin
            mProto[k] = 1'b1;
            return;
        end
        m    = wr ? we : oe;
        off  = int'(addr[1:0]);
        base = int'(addr[13:2]) * 4;
        mis  = ((m == 4'b0011) && (off % 2 == 1)) || ((m == 4'b1111) && (off != 0));
        if (mis) mMis[k] = 1'b1;
        if (wr) begin
            mWr[k] = mWr[k] + 32'd1;
            if (!mis) begin
                for (int i = 0; i < 4; i++) begin
                    if (m[i]) mdl[k][base + off + i] = wdata[8*i +: 8];
                end
            end
        end else begin
            mRd[k]       = mRd[k] + 32'd1;
            lastRdAcc[k] = cyc;
            dueCyc[k]    = cyc + lat[k];
            dueData[k]   = 32'd0;
            if (!mis) begin
                for (int i = 0; i < 4; i++) begin
                    if (m[i]) dueData[k][8*i +: 8] = mdl[k][base + off + i];
                end
            end
        end
    endtask

    task automatic tick(input logic [31:0] a, input logic [3:0] o, input logic [31:0] d, input logic [3:0] w);
        addr  = a;
        oe    = o;
        wdata = d;
        we    = w;
        for (int k = 0; k < 2; k++) modelAccept(k);
        @(negedge clk);
        cyc++;
        for (int k = 0; k < 2; k++) begin
            if (cyc == dueCyc[k]) expRdata[k] = dueData[k];
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) tick(32'd0, 4'd0, 32'd0, 4'd0);
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (obsValid[k] !== 1'b0 || obsReady[k] !== 1'b0 || obsRdata[k] !== 32'd0) begin
                errors++;
                $display("[TB] FAIL reset_outputs dut%0d got valid=%b ready=%b rdata=%h want 0 0 0",
                         k, obsValid[k], obsReady[k], obsRdata[k]);
            end
            checks++;
            if (obsMis[k] !== 1'b0 || obsProto[k] !== 1'b0 || obsRd[k] !== 32'd0 || obsWr[k] !== 32'd0) begin
                errors++;
                $display("[TB] FAIL reset_flags dut%0d got mis=%b proto=%b rd=%0d wr=%0d want all 0",
                         k, obsMis[k], obsProto[k], obsRd[k], obsWr[k]);
            end
        end
        rst = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (obsReady[k] !== 1'b1) begin
                errors++;
                $display("[TB] FAIL reset_release_ready dut%0d got %b want 1", k, obsReady[k]);
            end
        end
    endtask

    task automatic test_prefill();
        for (int w = 0; w < 128; w++) begin
            tick(($urandom() & 32'hFFFF_C000) | 32'(w * 4), 4'b0000, $urandom(), 4'b1111);
        end
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (obsWr[k] !== 32'd128 || obsValid[k] !== 1'b0) begin
                errors++;
                $display("[TB] FAIL prefill dut%0d got wr_cnt=%0d valid=%b want 128 0", k, obsWr[k], obsValid[k]);
            end
        end
    endtask

    task automatic test_raw_word();
        tick(32'h0000_0100, 4'b0000, 32'hDEAD_BEEF, 4'b1111);
        tick(32'h0000_0100, 4'b1111, 32'd0, 4'b0000);
        checks++;
        if (obsValid[0] !== 1'b1 || obsRdata[0] !== 32'hDEAD_BEEF) begin
            errors++;
            $display("[TB] FAIL raw_word dut0 got valid=%b rdata=%h want 1 deadbeef", obsValid[0], obsRdata[0]);
        end
        checks++;
        if (obsWr[0] !== 32'd129 || obsRd[0] !== 32'd1) begin
            errors++;
            $display("[TB] FAIL raw_counts dut0 got wr=%0d rd=%0d want 129 1", obsWr[0], obsRd[0]);
        end
        checks++;
        if (obsValid[1] !== 1'b0 || obsReady[1] !== 1'b0) begin
            errors++;
            $display("[TB] FAIL raw_wait dut1 got valid=%b ready=%b want 0 0", obsValid[1], obsReady[1]);
        end
        for (int n = 0; n < 4; n++) begin
            tick(32'd0, 4'd0, 32'd0, 4'd0);
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (obsValid[k] !== modelValid(k) || obsRdata[k] !== expRdata[k]) begin
                    errors++;
                    $display("[TB] FAIL raw_drain dut%0d cyc %0d got valid=%b rdata=%h want %b %h",
                             k, cyc, obsValid[k], obsRdata[k], modelValid(k), expRdata[k]);
                end
            end
        end
    endtask

    task automatic test_byte_half();
        logic [31:0] rdAddr [2];
        logic [3:0]  rdMask [2];
        logic [31:0] rdWant [2];
        rdAddr = '{32'h0000_0102, 32'h0000_0101};
        rdMask = '{4'b0011, 4'b0001};
        rdWant = '{32'h0000_5AAD, 32'h0000_00BE};
        tick(32'h0000_0103, 4'b0000, 32'h0000_005A, 4'b0001);
        for (int r = 0; r < 2; r++) begin
            tick(rdAddr[r], rdMask[r], 32'd0, 4'b0000);
            checks++;
            if (obsValid[0] !== 1'b1 || obsRdata[0] !== rdWant[r]) begin
                errors++;
                $display("[TB] FAIL byte_half_read%0d dut0 got valid=%b rdata=%h want 1 %h",
                         r, obsValid[0], obsRdata[0], rdWant[r]);
            end
            for (int n = 0; n < 4; n++) begin
                tick(32'd0, 4'd0, 32'd0, 4'd0);
                for (int k = 0; k < 2; k++) begin
                    checks++;
                    if (obsValid[k] !== modelValid(k) || obsRdata[k] !== expRdata[k]) begin
                        errors++;
                        $display("[TB] FAIL byte_half_drain dut%0d cyc %0d got valid=%b rdata=%h want %b %h",
                                 k, cyc, obsValid[k], obsRdata[k], modelValid(k), expRdata[k]);
                    end
                end
            end
        end
    endtask

    task automatic test_wait_proto();
        tick(32'h0000_0100, 4'b1111, 32'd0, 4'b0000);
        checks++;
        if (obsReady[1] !== 1'b0) begin
            errors++;
            $display("[TB] FAIL wait_ready_t1 dut1 got %b want 0", obsReady[1]);
        end
        tick(32'd0, 4'd0, 32'd0, 4'd0);
        checks++;
        if (obsReady[1] !== 1'b0 || obsValid[1] !== 1'b0) begin
            errors++;
            $display("[TB] FAIL wait_ready_t2 dut1 got ready=%b valid=%b want 0 0", obsReady[1], obsValid[1]);
        end
        tick(32'h0000_00F0, 4'b1111, 32'd0, 4'b0000);
        checks++;
        if (obsValid[1] !== 1'b1 || obsRdata[1] !== expRdata[1] || obsProto[1] !== 1'b1) begin
            errors++;
            $display("[TB] FAIL wait_resp dut1 got valid=%b rdata=%h proto=%b want 1 %h 1",
                     obsValid[1], obsRdata[1], obsProto[1], expRdata[1]);
        end
        checks++;
        if (obsProto[0] !== 1'b0 || obsValid[0] !== 1'b1 || obsRdata[0] !== expRdata[0]) begin
            errors++;
            $display("[TB] FAIL wait_fast dut0 got proto=%b valid=%b rdata=%h want 0 1 %h",
                     obsProto[0], obsValid[0], obsRdata[0], expRdata[0]);
        end
        for (int n = 0; n < 4; n++) begin
            tick(32'd0, 4'd0, 32'd0, 4'd0);
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (obsValid[k] !== modelValid(k) || obsRd[k] !== mRd[k]) begin
                    errors++;
                    $display("[TB] FAIL wait_drain dut%0d cyc %0d got valid=%b rd=%0d want %b %0d",
                             k, cyc, obsValid[k], obsRd[k], modelValid(k), mRd[k]);
                end
            end
        end
    endtask

    task automatic test_misalign();
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (obsMis[k] !== 1'b0) begin
                errors++;
                $display("[TB] FAIL misalign_before dut%0d got %b want 0", k, obsMis[k]);
            end
        end
        tick(32'h0000_0102, 4'b1111, 32'd0, 4'b0000);
        checks++;
        if (obsValid[0] !== 1'b1 || obsRdata[0] !== 32'd0 || obsMis[0] !== 1'b1) begin
            errors++;
            $display("[TB] FAIL misalign_read dut0 got valid=%b rdata=%h mis=%b want 1 0 1",
                     obsValid[0], obsRdata[0], obsMis[0]);
        end
        repeat (4) tick(32'd0, 4'd0, 32'd0, 4'd0);
        tick(32'h0000_00F6, 4'b0000, 32'hFFFF_FFFF, 4'b1111);
        tick(32'h0000_00F4, 4'b1111, 32'd0, 4'b0000);
        for (int n = 0; n < 4; n++) begin
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (obsValid[k] !== modelValid(k) || obsRdata[k] !== expRdata[k] || obsMis[k] !== 1'b1) begin
                    errors++;
                    $display("[TB] FAIL misalign_ram dut%0d cyc %0d got valid=%b rdata=%h mis=%b want %b %h 1",
                             k, cyc, obsValid[k], obsRdata[k], obsMis[k], modelValid(k), expRdata[k]);
                end
            end
            tick(32'd0, 4'd0, 32'd0, 4'd0);
        end
    endtask

    task automatic test_alias();
        tick(32'h4000_0100, 4'b0000, 32'h1122_3344, 4'b1111);
        tick(32'h0000_0100, 4'b1111, 32'd0, 4'b0000);
        checks++;
        if (obsValid[0] !== 1'b1 || obsRdata[0] !== 32'h1122_3344) begin
            errors++;
            $display("[TB] FAIL alias dut0 got valid=%b rdata=%h want 1 11223344", obsValid[0], obsRdata[0]);
        end
        for (int n = 0; n < 4; n++) begin
            tick(32'd0, 4'd0, 32'd0, 4'd0);
            checks++;
            if (obsValid[1] !== modelValid(1) || obsRdata[1] !== expRdata[1]) begin
                errors++;
                $display("[TB] FAIL alias_drain dut1 cyc %0d got valid=%b rdata=%h want %b %h",
                         cyc, obsValid[1], obsRdata[1], modelValid(1), expRdata[1]);
            end
        end
    endtask

    task automatic test_reset_midread();
        tick(32'h0000_0108, 4'b0000, 32'hCAFE_F00D, 4'b1111);
        tick(32'h0000_0108, 4'b1111, 32'd0, 4'b0000);
        rst = 1'b1;
        tick(32'd0, 4'd0, 32'd0, 4'd0);
        rst = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (obsReady[k] !== 1'b1 || obsRd[k] !== 32'd0 || obsWr[k] !== 32'd0 || obsRdata[k] !== 32'd0) begin
                errors++;
                $display("[TB] FAIL midread_release dut%0d got ready=%b rd=%0d wr=%0d rdata=%h want 1 0 0 0",
                         k, obsReady[k], obsRd[k], obsWr[k], obsRdata[k]);
            end
        end
        for (int n = 0; n < 4; n++) begin
            tick(32'd0, 4'd0, 32'd0, 4'd0);
            checks++;
            if (obsValid[1] !== 1'b0) begin
                errors++;
                $display("[TB] FAIL midread_abort dut1 cyc %0d got valid=%b want 0", cyc, obsValid[1]);
            end
        end
        tick(32'h0000_0108, 4'b1111, 32'd0, 4'b0000);
        for (int n = 0; n < 4; n++) begin
            for (int k = 0; k < 2; k++) begin
                if (modelValid(k)) begin
                    checks++;
                    if (obsValid[k] !== 1'b1 || obsRdata[k] !== 32'hCAFE_F00D) begin
                        errors++;
                        $display("[TB] FAIL midread_ram dut%0d got valid=%b rdata=%h want 1 cafef00d",
                                 k, obsValid[k], obsRdata[k]);
                    end
                end
            end
            tick(32'd0, 4'd0, 32'd0, 4'd0);
        end
    endtask

    task automatic test_random();
        logic [31:0] a;
        logic [3:0]  m;
        int          cls;
        int          pick;
        for (int n = 0; n < 2000; n++) begin
            a    = ($urandom() & 32'hFFFF_C000) | 32'($urandom_range(0, 511));
            pick = $urandom_range(0, 2);
            m    = (pick == 0) ? 4'b0001 : (pick == 1) ? 4'b0011 : 4'b1111;
            cls  = $urandom_range(0, 9);
            if (cls < 4)      tick(a, m, $urandom(), 4'b0000);
            else if (cls < 8) tick(a, 4'($urandom()), $urandom(), m);
            else              tick(a, 4'b0000, $urandom(), 4'b0000);
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (obsValid[k] !== modelValid(k) || obsRdata[k] !== expRdata[k]) begin
                    errors++;
                    $display("[TB] FAIL rand_resp dut%0d cyc %0d got valid=%b rdata=%h want %b %h",
                             k, cyc, obsValid[k], obsRdata[k], modelValid(k), expRdata[k]);
                end
                checks++;
                if (obsReady[k] !== modelReady(k) || obsMis[k] !== mMis[k] || obsProto[k] !== mProto[k]) begin
                    errors++;
                    $display("[TB] FAIL rand_flags dut%0d cyc %0d got ready=%b mis=%b proto=%b want %b %b %b",
                             k, cyc, obsReady[k], obsMis[k], obsProto[k], modelReady(k), mMis[k], mProto[k]);
                end
                checks++;
                if (obsRd[k] !== mRd[k] || obsWr[k] !== mWr[k]) begin
                    errors++;
                    $display("[TB] FAIL rand_counts dut%0d cyc %0d got rd=%0d wr=%0d want %0d %0d",
                             k, cyc, obsRd[k], obsWr[k], mRd[k], mWr[k]);
                end
            end
        end
    endtask

    initial begin
        rst   = 1'b1;
        addr  = 32'd0;
        oe    = 4'd0;
        wdata = 32'd0;
        we    = 4'd0;
        for (int k = 0; k < 2; k++) modelAccept(k);
        @(negedge clk);
        test_reset();
        test_prefill();
        test_raw_word();
        test_byte_half();
        test_wait_proto();
        test_misalign();
        test_alias();
        test_reset_midread();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
